// File: rtl/serializer_pkg.sv
// -----------------------------------------------------------------------------
// serializer_pkg
// Shared types and constants for the word-to-byte frame serializer.
//   state_e       : frame FSM states (IDLE, HEADER, PAYLOAD, CHECKSUM)
//   byte_width_lp : width of one output byte
// -----------------------------------------------------------------------------
package serializer_pkg;

    localparam int byte_width_lp = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HEADER   = 2'd1,
        PAYLOAD  = 2'd2,
        CHECKSUM = 2'd3
    } state_e;

endpackage

// File: rtl/counter.sv
// -----------------------------------------------------------------------------
// counter
// Up counter with synchronous clear and asynchronous active-low reset.
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset (count -> 0)
//   i_clr   : synchronous clear, wins over i_up
//   i_up    : increment by one
//   o_count : current count
// -----------------------------------------------------------------------------
module counter #(
    parameter int width_p = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    input  logic               i_up,
    output logic [width_p-1:0] o_count
);

    logic [width_p-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_up) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/word_byte_serializer.sv
// -----------------------------------------------------------------------------
// word_byte_serializer
// Pops one word over valid/ready and emits it as a byte frame:
//   [header] payload bytes LSB first [XOR checksum of payload bytes]
// Ports:
//   clk_i    : clock, all state on rising edge
//   reset_ni : asynchronous active-low reset, aborts any frame in progress
//   data_i   : input word
//   valid_i  : input word available
//   ready_o  : serializer accepts a word (only in IDLE, registered)
//   data_o   : output byte
//   valid_o  : output byte valid
//   ready_i  : downstream accepts the byte
//   busy_o   : a frame is in progress
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Once valid_o is raised, valid_o and data_o hold until ready_i is seen;
// ready_o never depends combinationally on ready_i.
// -----------------------------------------------------------------------------
module word_byte_serializer
    import serializer_pkg::*;
#(
    parameter int          word_width_p  = 32,
    parameter bit          header_en_p   = 1'b1,
    parameter logic [7:0]  header_val_p  = 8'hA5,
    parameter bit          checksum_en_p = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic [word_width_p-1:0] data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [7:0]              data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    busy_o
);

    localparam int N     = word_width_p / byte_width_lp;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_e                  r_state;
    state_e                  w_state_next;
    logic                    r_ready;
    logic [word_width_p-1:0] r_word;
    logic [7:0]              r_csum;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_accept;
    logic                    w_payload_up;
    logic                    w_last;
    logic                    w_valid;
    logic [7:0]              w_data;
    logic [7:0]              w_bytes [N];

    for (genvar g = 0; g < N; g++) begin : g_bytes
        assign w_bytes[g] = r_word[g*byte_width_lp +: byte_width_lp];
    end

    assign w_accept     = valid_i & r_ready & (r_state == IDLE);
    assign w_payload_up = (r_state == PAYLOAD) & w_valid & ready_i;
    assign w_last       = (w_idx == LAST_IDX);

    // Byte index: cleared when a new word is captured and when the last
    // payload byte leaves, so a fresh frame always starts at byte 0.
    counter #(
        .width_p (IDX_W)
    ) u_idx (
        .i_clk   (clk_i),
        .i_rst_n (reset_ni),
        .i_clr   (w_accept | (w_payload_up & w_last)),
        .i_up    (w_payload_up),
        .o_count (w_idx)
    );

    always_comb begin
        w_state_next = r_state;
        w_valid      = 1'b0;
        w_data       = 8'h00;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = header_en_p ? HEADER : PAYLOAD;
                end
            end
            HEADER: begin
                w_valid = 1'b1;
                w_data  = header_val_p;
                if (ready_i) begin
                    w_state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                w_valid = 1'b1;
                w_data  = w_bytes[w_idx];
                if (ready_i && w_last) begin
                    w_state_next = checksum_en_p ? CHECKSUM : IDLE;
                end
            end
            CHECKSUM: begin
                w_valid = 1'b1;
                w_data  = r_csum;
                if (ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_word  <= '0;
            r_csum  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            // Registered so ready_o stays low during reset and rises on the
            // first edge after release, without a path from ready_i.
            r_ready <= (w_state_next == IDLE);
            if (w_accept) begin
                r_word <= data_i;
                r_csum <= 8'h00;
            end else if (w_payload_up) begin
                r_csum <= r_csum ^ w_data;
            end
        end
    end

    assign ready_o = r_ready;
    assign valid_o = w_valid;
    assign data_o  = w_data;
    assign busy_o  = (r_state != IDLE);

endmodule

// File: tb/tb_word_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_byte_serializer
// Directed bench for word_byte_serializer. Two instances: u_dut_a with default
// options and u_dut_b with header and checksum disabled. Inputs are driven and
// outputs sampled on the falling edge; a byte counts as transferred when
// valid_o and the ready_i being presented are both high at that falling edge.
// -----------------------------------------------------------------------------
module tb_word_byte_serializer;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] data_i_a, data_i_b;
    logic        valid_i_a, valid_i_b;
    logic        ready_o_a, ready_o_b;
    logic [7:0]  data_o_a, data_o_b;
    logic        valid_o_a, valid_o_b;
    logic        ready_i_a, ready_i_b;
    logic        busy_o_a, busy_o_b;

    logic [7:0]  exp_q [$];
    int          acc_cyc [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    word_byte_serializer u_dut_a (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .data_i   (data_i_a),
        .valid_i  (valid_i_a),
        .ready_o  (ready_o_a),
        .data_o   (data_o_a),
        .valid_o  (valid_o_a),
        .ready_i  (ready_i_a),
        .busy_o   (busy_o_a)
    );

    word_byte_serializer #(
        .word_width_p  (32),
        .header_en_p   (1'b0),
        .header_val_p  (8'hA5),
        .checksum_en_p (1'b0)
    ) u_dut_b (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .data_i   (data_i_b),
        .valid_i  (valid_i_b),
        .ready_o  (ready_o_b),
        .data_o   (data_o_b),
        .valid_o  (valid_o_b),
        .ready_i  (ready_i_b),
        .busy_o   (busy_o_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Called at a falling edge with the selected DUT idle.
    task automatic check_idle(input bit sel, input string tag);
        check_eq({tag, "_ready"}, sel ? ready_o_b : ready_o_a, 1);
        check_eq({tag, "_valid"}, sel ? valid_o_b : valid_o_a, 0);
        check_eq({tag, "_busy"},  sel ? busy_o_b  : busy_o_a,  0);
    endtask

    // Presents one word, waits for the handshake, returns at the falling edge
    // where the first byte should already be valid.
    task automatic push(input bit sel, input logic [31:0] w);
        int t = 0;
        while (!(sel ? ready_o_b : ready_o_a) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("push_ready", sel ? ready_o_b : ready_o_a, 1);
        if (sel) begin valid_i_b = 1'b1; data_i_b = w; end
        else     begin valid_i_a = 1'b1; data_i_a = w; end
        @(negedge clk);
        // Junk on data_i outside IDLE must be ignored.
        if (sel) begin valid_i_b = 1'b0; data_i_b = 32'hDEADBEEF; end
        else     begin valid_i_a = 1'b0; data_i_a = 32'hDEADBEEF; end
        check_eq("first_byte_latency", sel ? valid_o_b : valid_o_a, 1);
    endtask

    // mode 0: ready always 1, no bubbles allowed
    // mode 1: ready pattern 1,0,0,1 repeating
    // mode 2: ready always 1, idle gaps allowed (back-to-back frames)
    task automatic drain(input bit sel, input int mode, input int max_cycles);
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [7:0] held = 8'h00;
        logic [7:0] d;
        logic       v, r_o, bsy;
        bit         rdy;
        int         pat [4] = '{1, 0, 0, 1};
        acc_cyc.delete();
        while (exp_q.size() != 0 && cyc < max_cycles) begin
            if (cyc != 0) @(negedge clk);
            v   = sel ? valid_o_b : valid_o_a;
            d   = sel ? data_o_b  : data_o_a;
            r_o = sel ? ready_o_b : ready_o_a;
            bsy = sel ? busy_o_b  : busy_o_a;
            rdy = (mode == 1) ? (pat[cyc % 4] != 0) : 1'b1;
            if (sel) ready_i_b = rdy;
            else     ready_i_a = rdy;
            check_eq("busy_vs_valid", {31'd0, bsy}, {31'd0, v});
            check_eq("ready_o_in_frame", {31'd0, r_o & v}, 0);
            if (mode == 0) check_eq("no_bubble", v, 1);
            if (stalled) begin
                check_eq("stall_valid", v, 1);
                check_eq("stall_data", d, held);
            end
            if (v && rdy) begin
                check_eq("byte", d, exp_q.pop_front());
                acc_cyc.push_back(cyc);
            end
            stalled = v && !rdy;
            held    = d;
            cyc++;
        end
        if (exp_q.size() != 0) begin
            check_eq("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        data_i_a  = '0; valid_i_a = 1'b0; ready_i_a = 1'b0;
        data_i_b  = '0; valid_i_b = 1'b0; ready_i_b = 1'b0;

        // Reset, then idle
        #1;
        check_eq("rst_ready", ready_o_a, 0);
        check_eq("rst_valid", valid_o_a, 0);
        check_eq("rst_busy",  busy_o_a,  0);
        check_eq("rst_data",  data_o_a,  8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel_ready_before_edge", ready_o_a, 0);
        @(negedge clk);
        check_idle(0, "rel_a");
        check_idle(1, "rel_b");

        // Basic frame
        push(0, 32'hA1B2C3D4);
        exp_q = '{8'hA5, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h04};
        drain(0, 0, 6);
        @(negedge clk);
        check_idle(0, "basic_end");

        // Back-pressure
        push(0, 32'hA1B2C3D4);
        exp_q = '{8'hA5, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h04};
        drain(0, 1, 40);
        @(negedge clk);
        check_idle(0, "bp_end");

        // Options off
        push(1, 32'h00FF1234);
        exp_q = '{8'h34, 8'h12, 8'hFF, 8'h00};
        drain(1, 0, 4);
        @(negedge clk);
        check_idle(1, "nohc_end");

        // Back-to-back with valid_i held
        exp_q = '{8'hA5, 8'h11, 8'h11, 8'h11, 8'h11, 8'h00,
                  8'hA5, 8'h22, 8'h22, 8'h22, 8'h22, 8'h00};
        fork
            begin
                logic [31:0] w_q [$];
                w_q = '{32'h11111111, 32'h22222222};
                for (int t = 0; t < 60 && w_q.size() != 0; t++) begin
                    valid_i_a = 1'b1;
                    data_i_a  = w_q[0];
                    if (ready_o_a) void'(w_q.pop_front());
                    @(negedge clk);
                end
                valid_i_a = 1'b0;
            end
            drain(0, 2, 60);
        join
        if (acc_cyc.size() == 12) check_eq("bb_gap", acc_cyc[6] - acc_cyc[5], 2);
        else                      check_eq("bb_count", acc_cyc.size(), 12);
        @(negedge clk);
        check_idle(0, "bb_end");

        // Reset mid-frame at payload idx 2
        push(0, 32'hA1B2C3D4);
        exp_q = '{8'hA5, 8'hD4, 8'hC3};
        drain(0, 0, 3);
        @(negedge clk);
        ready_i_a = 1'b0;
        check_eq("pre_rst_data_idx2", data_o_a, 8'hB2);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", valid_o_a, 0);
        check_eq("midrst_busy",  busy_o_a,  0);
        check_eq("midrst_ready", ready_o_a, 0);
        check_eq("midrst_data",  data_o_a,  8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(0, "midrst_rel");
        push(0, 32'h00000001);
        exp_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        drain(0, 0, 6);
        @(negedge clk);
        check_idle(0, "midrst_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
